// File: rtl/filter_chan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : filter_chan_ctrl
//  Brief    : Per-channel sequencer for the IIR pedestal-recovery / CFD
//             trigger filter. It steps the filter through the states
//             flush -> settle -> armed -> holdoff. It accepts run-time
//             threshold/output-select updates over a valid/ready handshake.
//             It turns the raw filter trigger into one-cycle pulses with
//             dead time, and counts them.
//  Revision : 1.0 - initial release
// ============================================================================
module filter_chan_ctrl #(
   parameter int FLUSH_CYCLES      = 4,
   parameter int SETTLE_CYCLES     = 64,
   parameter int HOLDOFF_CYCLES    = 256,
   parameter int THRESHOLD_DEFAULT = 45
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        run,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [31:0] cfg_threshold,
   input  logic        cfg_output_sel,
   input  logic        count_clear,
   input  logic        filt_trigger,
   output logic        filt_enable,
   output logic        filt_n_1_reset,
   output logic [31:0] filt_threshold,
   output logic        filt_output_sel,
   output logic        trig_out,
   output logic [15:0] trig_count,
   output logic [2:0]  state
);

   localparam logic [2:0] c_S_IDLE    = 3'd0;
   localparam logic [2:0] c_S_FLUSH   = 3'd1;
   localparam logic [2:0] c_S_SETTLE  = 3'd2;
   localparam logic [2:0] c_S_ARMED   = 3'd3;
   localparam logic [2:0] c_S_HOLDOFF = 3'd4;

   // The phase counter is loaded with N-1 on entry and the state ends when it reads 0.
   localparam logic [15:0] c_FLUSH_LOAD   = 16'(FLUSH_CYCLES - 1);
   localparam logic [15:0] c_SETTLE_LOAD  = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] c_HOLDOFF_LOAD = 16'(HOLDOFF_CYCLES - 1);
   localparam logic [31:0] c_THRESH_RST   = 32'(THRESHOLD_DEFAULT);

   logic [2:0]  r_state;
   logic [2:0]  w_state_next;
   logic [15:0] r_phase;
   logic [15:0] w_phase_load;
   logic        w_phase_done;
   logic        r_trig_q;
   logic        w_trig_edge;
   logic        w_cfg_accept;
   logic        w_trig_accept;
   logic        r_trig_out;
   logic [15:0] r_trig_count;
   logic [31:0] r_threshold;
   logic        r_output_sel;
   logic        w_enable;
   logic        w_n_1_reset;
   logic        w_cfg_ready;

   assign w_phase_done  = (r_phase == 16'd0);
   assign w_trig_edge   = filt_trigger && !r_trig_q;
   assign w_cfg_accept  = cfg_valid && w_cfg_ready;
   // A configuration write in ARMED takes precedence over a coincident edge. A stop request also suppresses the edge.
   assign w_trig_accept = (r_state == c_S_ARMED) && run && w_trig_edge && !w_cfg_accept;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: dropping run returns to IDLE from any state, ahead of every other transition
   always_comb begin
      w_state_next = r_state;
      if ((r_state != c_S_IDLE) && !run) begin
         w_state_next = c_S_IDLE;
      end else begin
         case (r_state)
            c_S_IDLE:    if (run)           w_state_next = c_S_FLUSH;
            c_S_FLUSH:   if (w_phase_done)  w_state_next = c_S_SETTLE;
            c_S_SETTLE:  if (w_phase_done)  w_state_next = c_S_ARMED;
            c_S_ARMED: begin
               if (w_cfg_accept)            w_state_next = c_S_SETTLE;
               else if (w_trig_accept)      w_state_next = c_S_HOLDOFF;
            end
            c_S_HOLDOFF: if (w_phase_done)  w_state_next = c_S_ARMED;
            default:                        w_state_next = c_S_IDLE;
         endcase
      end
   end

   // Output decode, taken from the state register only
   always_comb begin
      w_enable    = 1'b0;
      w_n_1_reset = 1'b0;
      w_cfg_ready = 1'b0;
      case (r_state)
         c_S_IDLE:    w_cfg_ready = 1'b1;
         c_S_FLUSH:   w_n_1_reset = 1'b1;
         c_S_SETTLE:  w_enable    = 1'b1;
         c_S_ARMED: begin
            w_enable    = 1'b1;
            w_cfg_ready = 1'b1;
         end
         c_S_HOLDOFF: w_enable    = 1'b1;
         default: ;
      endcase
   end

   // Select the duration for the state that is about to be entered
   always_comb begin
      w_phase_load = 16'd0;
      case (w_state_next)
         c_S_FLUSH:   w_phase_load = c_FLUSH_LOAD;
         c_S_SETTLE:  w_phase_load = c_SETTLE_LOAD;
         c_S_HOLDOFF: w_phase_load = c_HOLDOFF_LOAD;
         default:     w_phase_load = 16'd0;
      endcase
   end

   // Phase counter: load on every state change, then count down to zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= 16'd0;
      end else if (w_state_next != r_state) begin
         r_phase <= w_phase_load;
      end else if (!w_phase_done) begin
         r_phase <= r_phase - 16'd1;
      end
   end

   // Sample the raw trigger every cycle; a trigger already high when ARMED is entered therefore does not fire
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_trig_q <= 1'b0;
      end else begin
         r_trig_q <= filt_trigger;
      end
   end

   // Qualified trigger pulse, high for the one cycle after the accepting edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_trig_out <= 1'b0;
      end else begin
         r_trig_out <= w_trig_accept;
      end
   end

   // Saturating trigger counter; a clear overrides a coincident increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_trig_count <= 16'd0;
      end else if (count_clear) begin
         r_trig_count <= 16'd0;
      end else if (w_trig_accept && (r_trig_count != 16'hFFFF)) begin
         r_trig_count <= r_trig_count + 16'd1;
      end
   end

   // Configuration registers, updated on the accepting edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_threshold  <= c_THRESH_RST;
         r_output_sel <= 1'b0;
      end else if (w_cfg_accept) begin
         r_threshold  <= cfg_threshold;
         r_output_sel <= cfg_output_sel;
      end
   end

   assign state           = r_state;
   assign filt_enable     = w_enable;
   assign filt_n_1_reset  = w_n_1_reset;
   assign cfg_ready       = w_cfg_ready;
   assign filt_threshold  = r_threshold;
   assign filt_output_sel = r_output_sel;
   assign trig_out        = r_trig_out;
   assign trig_count      = r_trig_count;

endmodule
`default_nettype wire
